rr_channel_arbiter: RTL and testbench

Clocked round-robin arbiter that shares one 4-phase bundled-data output channel among NUM_REQ requesting channels, e.g. merging the two fan-out branches of a PE copy stage, or several PE results, onto one router input. It grants one requester at a time and latches that requester's data. It completes the full 4-phase handshake on the output before acknowledging the granted input.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_priority_select.sv | 36 +++
 rtl/rr_channel_arbiter.sv | 112 +++++++++++
 tb/tb_rr_channel_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared state type and limits for the round-robin output-channel arbiter.
package arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OUT_REQ = 2'd1,
    OUT_REL = 2'd2,
    IN_ACK  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: rotate the request vector so ptr sits at bit 0,
// take the lowest set bit, then map that offset back to a requester index.
module rr_priority_select #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] winner
);

  logic [N-1:0]   rot;
  logic [IDW-1:0] offs;
  logic [IDW:0]   sum;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[(i + int'(ptr)) % N];
    end
  end

  // Scan downwards so the lowest set bit of the rotated vector wins.
  always_comb begin
    offs = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) offs = IDW'(i);
    end
  end

  assign sum    = {1'b0, offs} + {1'b0, ptr};
  assign winner = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
  assign valid  = |req;

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter merging NUM_REQ 4-phase bundled-data channels onto one output;
// the output handshake completes fully before the granted input is acknowledged.
//
//   state   | meaning
//   IDLE    | waiting for a request with out_ack low; picks the next winner
//   OUT_REQ | out_req high with latched data, waiting for out_ack=1
//   OUT_REL | out_req dropped, waiting for out_ack=0
//   IN_ACK  | in_ack[grant_id] high, waiting for the requester to drop in_req
module rr_channel_arbiter #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       in_req,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]       in_ack,
  output logic                     out_req,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ack,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  import arb_pkg::*;

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("rr_channel_arbiter: NUM_REQ must be within 2..%0d", MAX_REQ);
  end

  arb_state_e         state, state_n;
  logic [ID_W-1:0]    ptr, ptr_n, grant_n;
  logic               out_req_n, busy_n;
  logic [WIDTH-1:0]   out_data_n;
  logic [NUM_REQ-1:0] in_ack_n;
  logic               sel_valid;
  logic [ID_W-1:0]    sel_winner;

  rr_priority_select #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_sel (
    .req    (in_req),
    .ptr    (ptr),
    .valid  (sel_valid),
    .winner (sel_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      out_req  <= 1'b0;
      out_data <= '0;
      in_ack   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      grant_id <= grant_n;
      out_req  <= out_req_n;
      out_data <= out_data_n;
      in_ack   <= in_ack_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_n    = grant_id;
    out_req_n  = out_req;
    out_data_n = out_data;
    in_ack_n   = in_ack;
    case (state)
      IDLE: begin
        // A stale out_ack from the previous transfer blocks new grants.
        if (sel_valid && !out_ack) begin
          grant_n    = sel_winner;
          out_data_n = in_data[int'(sel_winner)*WIDTH +: WIDTH];
          out_req_n  = 1'b1;
          state_n    = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (out_ack) begin
          out_req_n = 1'b0;
          state_n   = OUT_REL;
        end
      end
      OUT_REL: begin
        if (!out_ack) begin
          in_ack_n           = '0;
          in_ack_n[grant_id] = 1'b1;
          state_n            = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!in_req[grant_id]) begin
          in_ack_n = '0;
          ptr_n    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Self-checking bench: a 2-requester and a 4-requester arbiter driven by directed
// sequences, a vector table, and a randomized run against a round-robin model.
module tb_rr_channel_arbiter;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic        rst2, rst4;
  logic [1:0]  req2, iack2;
  logic [15:0] dat2;
  logic        oreq2, oack2, g2, busy2;
  logic [7:0]  od2;
  logic [3:0]  req4, iack4;
  logic [31:0] dat4;
  logic        oreq4, oack4, busy4;
  logic [1:0]  g4;
  logic [7:0]  od4;

  typedef struct {
    logic [3:0] req;
    int         id;
  } vec_t;
  vec_t tab[12];

  always #5 if (clk_en) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rr_channel_arbiter #(.WIDTH(8), .NUM_REQ(2)) dut2 (
    .clk(clk), .rst(rst2), .in_req(req2), .in_data(dat2), .in_ack(iack2),
    .out_req(oreq2), .out_data(od2), .out_ack(oack2), .grant_id(g2), .busy(busy2)
  );

  rr_channel_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut4 (
    .clk(clk), .rst(rst4), .in_req(req4), .in_data(dat4), .in_ack(iack4),
    .out_req(oreq4), .out_data(od4), .out_ack(oack4), .grant_id(g4), .busy(busy4)
  );

  function automatic logic [31:0] g_oreq(input int u);
    return (u == 0) ? 32'(oreq2) : 32'(oreq4);
  endfunction
  function automatic logic [31:0] g_od(input int u);
    return (u == 0) ? 32'(od2) : 32'(od4);
  endfunction
  function automatic logic [31:0] g_gid(input int u);
    return (u == 0) ? 32'(g2) : 32'(g4);
  endfunction
  function automatic logic [31:0] g_iack(input int u);
    return (u == 0) ? 32'(iack2) : 32'(iack4);
  endfunction
  function automatic logic [31:0] g_busy(input int u);
    return (u == 0) ? 32'(busy2) : 32'(busy4);
  endfunction
  function automatic logic [31:0] g_req(input int u);
    return (u == 0) ? 32'(req2) : 32'(req4);
  endfunction

  task automatic set_req(input int u, input logic [31:0] v);
    if (u == 0) req2 = v[1:0];
    else        req4 = v[3:0];
  endtask
  task automatic set_oack(input int u, input logic b);
    if (u == 0) oack2 = b;
    else        oack4 = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic rst_pulse(input int u);
    if (u == 0) rst2 = 1'b1; else rst4 = 1'b1;
    tick();
    if (u == 0) rst2 = 1'b0; else rst4 = 1'b0;
    tick();
  endtask

  task automatic check_zero(input int u, input string nm);
    chk({nm, " out_req"},  g_oreq(u), 0);
    chk({nm, " out_data"}, g_od(u),   0);
    chk({nm, " in_ack"},   g_iack(u), 0);
    chk({nm, " grant_id"}, g_gid(u),  0);
    chk({nm, " busy"},     g_busy(u), 0);
  endtask

  task automatic wait_oreq(input int u, input string nm);
    int n;
    n = 0;
    while (g_oreq(u) == 0 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " out_req within 20 cycles"}, g_oreq(u), 1);
  endtask

  // One complete transfer with a responder answering each edge one cycle later;
  // t returns the cycle at which out_req was seen high.
  task automatic xfer(input int u, input int id, input int d, input string nm, output int t);
    wait_oreq(u, nm);
    t = cyc;
    if (g_oreq(u) == 0) return;
    chk({nm, " grant_id"}, g_gid(u), id);
    chk({nm, " out_data"}, g_od(u),  d);
    set_oack(u, 1'b1);
    tick();
    chk({nm, " out_req release"}, g_oreq(u), 0);
    chk({nm, " in_ack before out_ack low"}, g_iack(u), 0);
    set_oack(u, 1'b0);
    tick();
    chk({nm, " in_ack"}, g_iack(u), 32'(1) << id);
    set_req(u, g_req(u) & ~(32'(1) << id));
    tick();
    chk({nm, " in_ack drop"}, g_iack(u), 0);
    chk({nm, " busy idle"},   g_busy(u), 0);
  endtask

  // Round-robin reference: the requester closest to ptr going upward (mod 4) wins.
  function automatic int rr_model(input logic [3:0] r, input int p);
    int best;
    int bd;
    best = -1;
    bd   = 99;
    for (int i = 0; i < 4; i++) begin
      if (r[i] && ((i - p + 4) % 4) < bd) begin
        bd   = (i - p + 4) % 4;
        best = i;
      end
    end
    return best;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, tprev, w, mptr, cur_id;
    logic [7:0] cur_data [4];
    logic [3:0] snap_req;
    logic snap_idle, prev_oreq, rise, exp_rise;

    tab[0]  = '{4'b1111, 0};  tab[1]  = '{4'b1111, 1};
    tab[2]  = '{4'b1111, 2};  tab[3]  = '{4'b1111, 3};
    tab[4]  = '{4'b1111, 0};  tab[5]  = '{4'b0001, 0};
    tab[6]  = '{4'b1000, 3};  tab[7]  = '{4'b0110, 1};
    tab[8]  = '{4'b0101, 2};  tab[9]  = '{4'b0011, 0};
    tab[10] = '{4'b1001, 3};  tab[11] = '{4'b0100, 2};

    rst2 = 1'b1; rst4 = 1'b1;
    req2 = '0; req4 = '0; dat2 = '0; dat4 = '0; oack2 = 1'b0; oack4 = 1'b0;
    tick(); tick();
    check_zero(0, "reset2");
    check_zero(1, "reset4");
    rst2 = 1'b0; rst4 = 1'b0;
    tick();
    chk("release busy",     g_busy(0), 0);
    chk("release grant_id", g_gid(0),  0);

    // Reset mid-transfer with the clock stopped.
    dat2[7:0] = 8'h33; req2 = 2'b01;
    tick();
    chk("pre-reset out_req", g_oreq(0), 1);
    clk_en = 1'b0;
    #20;
    rst2 = 1'b1;
    #1;
    check_zero(0, "async reset");
    req2 = 2'b00;
    #4;
    rst2 = 1'b0;
    clk_en = 1'b1;
    tick();
    chk("post-reset busy",     g_busy(0), 0);
    chk("post-reset grant_id", g_gid(0),  0);
    chk("post-reset out_req",  g_oreq(0), 0);

    // Single transfer from requester 1.
    dat2[15:8] = 8'hA5; req2 = 2'b10;
    tick();
    chk("single out_req next cycle", g_oreq(0), 1);
    chk("single out_data", g_od(0), 8'hA5);
    chk("single grant_id", g_gid(0), 1);
    oack2 = 1'b1;
    tick();
    chk("single out_req drop", g_oreq(0), 0);
    chk("single in_ack waits", g_iack(0), 0);
    tick();
    chk("single in_ack while out_ack high", g_iack(0), 0);
    oack2 = 1'b0;
    tick();
    chk("single in_ack", g_iack(0), 2'b10);
    chk("single grant_id hold", g_gid(0), 1);
    req2 = 2'b00;
    tick();
    chk("single in_ack drop", g_iack(0), 0);
    chk("single out_data hold", g_od(0), 8'hA5);

    // Simultaneous requests alternate 0x11, 0x22, 0x11, 0x22.
    rst_pulse(0);
    dat2 = {8'h22, 8'h11}; req2 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      xfer(0, k % 2, (k % 2 == 0) ? 8'h11 : 8'h22, "simul", t);
      req2 = 2'b11;
    end
    req2 = 2'b00;
    tick();

    // Lone requester: back-to-back transfers, 5 cycles apart.
    tprev = 0;
    for (int k = 0; k < 3; k++) begin
      dat2[7:0] = 8'(k + 1); req2 = 2'b01;
      xfer(0, 0, k + 1, "lone", t);
      if (k > 0) chk("lone spacing", 32'(t - tprev), 5);
      tprev = t;
      tick();
    end

    // Stale out_ack in IDLE blocks the grant until it drops.
    oack2 = 1'b1; dat2[7:0] = 8'h5A; req2 = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stale no out_req", g_oreq(0), 0);
      chk("stale not busy",   g_busy(0), 0);
    end
    oack2 = 1'b0;
    tick();
    chk("stale grant next edge", g_oreq(0), 1);
    xfer(0, 0, 8'h5A, "stale", t);
    req2 = 2'b00;

    // Vector table on the 4-requester arbiter.
    rst_pulse(1);
    dat4 = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    for (int e = 0; e < 12; e++) begin
      req4 = tab[e].req;
      xfer(1, tab[e].id, 8'hC0 + tab[e].id, "table", t);
    end
    req4 = '0;
    tick();

    // Reset during the second grant's OUT_REQ; next grant restarts at 0.
    rst_pulse(1);
    req4 = 4'b1111;
    xfer(1, 0, 8'hC0, "rot first", t);
    req4 = 4'b1111;
    wait_oreq(1, "rot second");
    chk("rot second grant_id", g_gid(1), 1);
    rst4 = 1'b1;
    #1;
    check_zero(1, "rot reset");
    tick();
    rst4 = 1'b0;
    xfer(1, 0, 8'hC0, "rot after reset", t);
    req4 = '0;
    tick();

    // Randomized traffic against the round-robin model.
    rst_pulse(1);
    mptr = 0; cur_id = 0; snap_req = '0; snap_idle = 1'b0; prev_oreq = 1'b0;
    for (int i = 0; i < 4; i++) cur_data[i] = '0;
    for (int c = 0; c < 3300; c++) begin
      tick();
      rise     = oreq4 && !prev_oreq;
      exp_rise = snap_idle && (snap_req != 0);
      if (rise || exp_rise) chk("rand grant timing", 32'(rise), 32'(exp_rise));
      if (rise && snap_req != 0) begin
        w = rr_model(snap_req, mptr);
        chk("rand grant_id", 32'(g4), w);
        chk("rand out_data", 32'(od4), 32'(cur_data[w]));
        cur_id = w;
        mptr   = (w + 1) % 4;
      end
      if (iack4 != 0) chk("rand in_ack", 32'(iack4), 32'(1) << cur_id);
      prev_oreq = oreq4;

      for (int i = 0; i < 4; i++) begin
        if (req4[i] && iack4[i]) begin
          req4[i] = 1'b0;
        end else if (!req4[i] && !iack4[i] && c < 3000 && $urandom_range(0, 3) == 0) begin
          cur_data[i]     = 8'($urandom);
          dat4[i*8 +: 8]  = cur_data[i];
          req4[i]         = 1'b1;
        end
      end
      if (oreq4 && !oack4) begin
        if ($urandom_range(0, 2) != 0) oack4 = 1'b1;
      end else if (!oreq4 && oack4) begin
        if ($urandom_range(0, 2) != 0) oack4 = 1'b0;
      end else if (!oreq4 && !oack4 && !busy4 && $urandom_range(0, 15) == 0) begin
        oack4 = 1'b1;
      end
      snap_req  = req4;
      snap_idle = !busy4 && !oack4;
    end
    chk("rand drained busy", 32'(busy4), 0);
    chk("rand drained req",  32'(req4),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
